// File: rtl/goc_pkg.sv
// goc_pkg: shared definitions for the GOC transmitter and receiver.
package goc_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_ABORT} goc_state_t;
    localparam int BIT_MULT  = 2;
    localparam int MAX_MULT  = 4;
    localparam int IDLE_MULT = 8;
    localparam int GOC_CNT_W = 25;
endpackage

// File: rtl/goc_sync_edge.sv
// goc_sync_edge: 2-flop synchronizer, polarity correction and edge detect for the GOC pad.
module goc_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic pad,
    input  logic polarity,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1, s2, prev;
    // Synchronizer resets to the idle pad level so leaving reset never fakes an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= polarity;
            s2    <= polarity;
            level <= 1'b0;
            prev  <= 1'b0;
        end else begin
            s1    <= pad;
            s2    <= s1;
            level <= s2 ^ polarity;
            prev  <= level;
        end
    end
    assign rise = level & ~prev;
    assign fall = ~level & prev;
endmodule

// File: rtl/goc_rx_demod.sv
// goc_rx_demod: GOC pulse-width demodulator; recovers MSB-first bytes and idle-delimited frames.
module goc_rx_demod
    import goc_pkg::*;
#(
    parameter int CNT_W = GOC_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        goc_pad_in,
    input  logic        goc_polarity,
    input  logic [21:0] goc_speed,
    output logic [7:0]  out_data,
    output logic        out_data_valid,
    output logic        out_frame_valid,
    output logic        out_frame_error
);
    goc_state_t state;
    logic [CNT_W-1:0] spd, t_bit, t_max, t_idle, cnt, cnt_inc;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic level, rise, fall, bit_val;

    goc_sync_edge u_sync (
        .clk      (clk),
        .reset    (reset),
        .pad      (goc_pad_in),
        .polarity (goc_polarity),
        .level    (level),
        .rise     (rise),
        .fall     (fall)
    );

    assign spd     = CNT_W'(goc_speed);
    assign t_bit   = spd * CNT_W'(BIT_MULT);
    assign t_max   = spd * CNT_W'(MAX_MULT);
    assign t_idle  = spd * CNT_W'(IDLE_MULT);
    assign cnt_inc = &cnt ? cnt : cnt + CNT_W'(1);
    assign bit_val = cnt >= t_bit;

    always_ff @(posedge clk) begin
        if (reset || goc_speed == '0) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            bit_cnt         <= '0;
            shreg           <= '0;
            out_data        <= '0;
            out_data_valid  <= 1'b0;
            out_frame_valid <= 1'b0;
            out_frame_error <= 1'b0;
        end else begin
            out_data_valid  <= 1'b0;
            out_frame_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    cnt     <= rise ? CNT_W'(1) : '0;
                    if (rise) begin
                        state           <= ST_HIGH;
                        out_frame_valid <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        shreg <= {shreg[6:0], bit_val};
                        state <= ST_LOW;
                        cnt   <= CNT_W'(1);
                        if (bit_cnt == 3'd7) begin
                            out_data       <= {shreg[6:0], bit_val};
                            out_data_valid <= 1'b1;
                            bit_cnt        <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else if (cnt >= t_max) begin
                        out_frame_error <= 1'b1;
                        bit_cnt         <= '0;
                        state           <= ST_ABORT;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        state <= ST_HIGH;
                        cnt   <= CNT_W'(1);
                    end else if (cnt >= t_idle) begin
                        state           <= ST_IDLE;
                        cnt             <= '0;
                        bit_cnt         <= '0;
                        out_frame_valid <= 1'b0;
                        out_frame_error <= bit_cnt != 3'd0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_ABORT: begin
                    if (fall) begin
                        state <= ST_LOW;
                        cnt   <= CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_goc_rx_demod.sv
// tb_goc_rx_demod: scoreboard bench for the GOC receive demodulator.
module tb_goc_rx_demod;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        goc_pad_in = 1'b0;
    logic        goc_polarity = 1'b0;
    logic [21:0] goc_speed = 22'd4;
    logic [7:0]  out_data;
    logic        out_data_valid, out_frame_valid, out_frame_error;

    int checks = 0, failures = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int n_dv, n_err, n_rise, n_fall, rise_cyc, fall_cyc, err_cyc;
    int first_k, last_fall_k;
    logic line_v, in_frame, fv_prev;

    goc_rx_demod dut (
        .clk             (clk),
        .reset           (reset),
        .goc_pad_in      (goc_pad_in),
        .goc_polarity    (goc_polarity),
        .goc_speed       (goc_speed),
        .out_data        (out_data),
        .out_data_valid  (out_data_valid),
        .out_frame_valid (out_frame_valid),
        .out_frame_error (out_frame_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard on every byte strobe and logs frame/error timing
    always @(negedge clk) begin
        if (out_data_valid) begin
            n_dv++;
            chk("data", {24'd0, out_data}, exp_q.size() > 0 ? {24'd0, exp_q.pop_front()} : 32'hDEAD);
            chk("dv_fe_excl", {31'd0, out_frame_error}, 32'd0);
        end
        if (out_frame_error) begin
            n_err++;
            err_cyc = cyc;
        end
        if (out_frame_valid && !fv_prev) begin
            n_rise++;
            rise_cyc = cyc;
        end
        if (!out_frame_valid && fv_prev) begin
            n_fall++;
            fall_cyc = cyc;
        end
        fv_prev = out_frame_valid;
    end

    task automatic start_test();
        n_dv = 0; n_err = 0; n_rise = 0; n_fall = 0;
        rise_cyc = -1; fall_cyc = -1; err_cyc = -1;
        in_frame = 1'b0;
        exp_q.delete();
    endtask

    // Drive the logical line level v for n clocks; pad edges register at the next posedge
    task automatic line(input logic v, input int n);
        if (v && !line_v && !in_frame) begin
            first_k = cyc + 1;
            in_frame = 1'b1;
        end
        if (!v && line_v) last_fall_k = cyc + 1;
        line_v = v;
        goc_pad_in = v ^ goc_polarity;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        line(1'b1, b ? 12 : 4);
        line(1'b0, b ? 4 : 12);
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        line_v = 1'b0;
        goc_pad_in = goc_polarity;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_checks(input string tag, input int strobes, input int errs);
        chk({tag, "_rise"}, rise_cyc, first_k + 3);
        chk({tag, "_fall"}, fall_cyc, last_fall_k + 35);
        chk({tag, "_nframe"}, n_rise, 1);
        chk({tag, "_ndv"}, n_dv, strobes);
        chk({tag, "_nerr"}, n_err, errs);
        chk({tag, "_qempty"}, exp_q.size(), 0);
    endtask

    initial begin
        line_v = 1'b0;
        fv_prev = 1'b0;
        start_test();
        repeat (3) @(negedge clk);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_dv", {31'd0, out_data_valid}, 32'd0);
        chk("rst_fv", {31'd0, out_frame_valid}, 32'd0);
        chk("rst_fe", {31'd0, out_frame_error}, 32'd0);
        do_reset();

        start_test();
        send_byte(8'hA5);
        line(1'b0, 40);
        frame_checks("single", 1, 0);
        chk("single_hold", {24'd0, out_data}, 32'hA5);

        goc_polarity = 1'b1;
        do_reset();
        start_test();
        line(1'b0, 30);
        chk("pol_idle_nframe", n_rise, 0);
        send_byte(8'hA5);
        line(1'b0, 40);
        frame_checks("pol", 1, 0);
        goc_polarity = 1'b0;
        do_reset();

        start_test();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        line(1'b0, 40);
        frame_checks("b2b", 3, 0);

        start_test();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        line(1'b0, 40);
        frame_checks("partial", 0, 1);
        chk("partial_err_at_end", err_cyc, fall_cyc);

        start_test();
        line(1'b1, 20);
        line(1'b0, 4);
        chk("long_err_cyc", err_cyc, first_k + 19);
        send_byte(8'h5A);
        line(1'b0, 40);
        frame_checks("long", 1, 1);

        start_test();
        send_bit(1'b1); send_bit(1'b0);
        line(1'b1, 6);
        chk("rst_mid_fv_before", {31'd0, out_frame_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_fv", {31'd0, out_frame_valid}, 32'd0);
        chk("rst_mid_data", {24'd0, out_data}, 32'd0);
        line(1'b0, 4);
        reset = 1'b0;
        line(1'b0, 40);
        chk("rst_mid_ndv", n_dv, 0);
        chk("rst_mid_nerr", n_err, 0);

        start_test();
        goc_speed = 22'd0;
        for (int i = 0; i < 20; i++) line(logic'(i % 2 == 0), $urandom_range(1, 20));
        line(1'b0, 10);
        goc_speed = 22'd4;
        line(1'b0, 10);
        chk("dis_nframe", n_rise, 0);
        chk("dis_ndv", n_dv, 0);
        chk("dis_nerr", n_err, 0);

        start_test();
        send_byte(8'hC3);
        line(1'b0, 40);
        frame_checks("reenable", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
